// File: rtl/semaforo_scheduler.sv
// Phase scheduler for a two-road intersection with pedestrian crossings.
// Sequences green/yellow/all-red phases from synchronized car sensors and
// latched pedestrian requests, paced by a prescaled timer tick. A walk phase
// is inserted after an all-red clearance whenever a pedestrian request is
// pending. Lamp lines, walk lamps, a countdown digit and a debug phase code
// are Moore-decoded from the registered state.
module semaforo_scheduler #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 15,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       sensor_a_i,
    input  logic       sensor_b_i,
    input  logic       paso_a_i,
    input  logic       paso_b_i,
    output logic       va_o,
    output logic       aa_o,
    output logic       ra_o,
    output logic       vb_o,
    output logic       ab_o,
    output logic       rb_o,
    output logic       walk_a_o,
    output logic       walk_b_o,
    output logic [3:0] numero_o,
    output logic [2:0] phase_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    TMAXG      = 4'(T_MAX_GREEN);
    localparam logic [4:0]    TMING5     = 5'(T_MIN_GREEN);
    localparam logic [4:0]    TMAXG5     = 5'(T_MAX_GREEN);

    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        ALLRED_A = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        ALLRED_B = 3'd5,
        WALK     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    e_q, e_d;
    logic [3:0]    tmr_q, tmr_d;
    logic [PW-1:0] presc_q;
    logic [3:0]    meta_q, sync_q;
    logic          ped_a_q, ped_b_q;
    logic          served_a_q, served_b_q;
    logic          next_b_q;

    logic          tick;
    logic          state_change;
    logic          enter_walk;
    logic          sens_a, sens_b, paso_a, paso_b;
    logic [4:0]    e_plus;
    logic          min_ok, max_ok, ped_any;
    logic          exit_a, exit_b;

    assign sens_a = sync_q[0];
    assign sens_b = sync_q[1];
    assign paso_a = sync_q[2];
    assign paso_b = sync_q[3];

    assign tick         = enable_i && (presc_q == PRESC_LAST);
    assign state_change = (state_d != state_q);
    assign enter_walk   = (state_d == WALK) && (state_q != WALK);

    // Green exit decision: e+1 is the elapsed count including the current tick.
    assign e_plus  = {1'b0, e_q} + 5'd1;
    assign min_ok  = (e_plus >= TMING5);
    assign max_ok  = (e_plus >= TMAXG5);
    assign ped_any = ped_a_q | ped_b_q;
    assign exit_a  = min_ok && (sens_b | ped_any) && (!sens_a || max_ok);
    assign exit_b  = min_ok && (sens_a | ped_any) && (!sens_b || max_ok);

    // Two-flop synchronizers for the asynchronous sensor and request inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b0;
            sync_q <= 4'b0;
        end else begin
            meta_q <= {paso_b_i, paso_a_i, sensor_b_i, sensor_a_i};
            sync_q <= meta_q;
        end
    end

    // Next-state, elapsed-green and phase-timer logic; advances only on tick.
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        tmr_d   = tmr_q;
        case (state_q)
            GREEN_A: begin
                if (tick) begin
                    if (exit_a)             state_d = YELLOW_A;
                    else if (e_q < TMAXG)   e_d = e_q + 4'd1;
                end
            end
            GREEN_B: begin
                if (tick) begin
                    if (exit_b)             state_d = YELLOW_B;
                    else if (e_q < TMAXG)   e_d = e_q + 4'd1;
                end
            end
            YELLOW_A, YELLOW_B, ALLRED_A, ALLRED_B, WALK: begin
                if (tick) begin
                    if (tmr_q == 4'd1) begin
                        case (state_q)
                            YELLOW_A: state_d = ALLRED_A;
                            YELLOW_B: state_d = ALLRED_B;
                            ALLRED_A: state_d = ped_any ? WALK : GREEN_B;
                            ALLRED_B: state_d = ped_any ? WALK : GREEN_A;
                            default:  state_d = next_b_q ? GREEN_B : GREEN_A;
                        endcase
                    end else begin
                        tmr_d = tmr_q - 4'd1;
                    end
                end
            end
            default: state_d = GREEN_A;
        endcase
        // Every phase entry restarts the elapsed count and loads its duration.
        if (state_d != state_q) begin
            e_d = 4'd0;
            case (state_d)
                YELLOW_A, YELLOW_B: tmr_d = 4'(T_YELLOW);
                ALLRED_A, ALLRED_B: tmr_d = 4'(T_ALLRED);
                WALK:               tmr_d = 4'(T_WALK);
                default:            tmr_d = 4'd0;
            endcase
        end
    end

    // State, timers and prescaler; the prescaler restarts on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GREEN_A;
            e_q     <= 4'd0;
            tmr_q   <= 4'd0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            tmr_q   <= tmr_d;
            if (state_change)
                presc_q <= '0;
            else if (enable_i)
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    // Pedestrian request latches, walk-lamp captures and road-order memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_a_q    <= 1'b0;
            ped_b_q    <= 1'b0;
            served_a_q <= 1'b0;
            served_b_q <= 1'b0;
            next_b_q   <= 1'b0;
        end else begin
            // Clearing on walk entry wins over a request seen in the same cycle.
            if (enter_walk)  ped_a_q <= 1'b0;
            else if (paso_a) ped_a_q <= 1'b1;
            if (enter_walk)  ped_b_q <= 1'b0;
            else if (paso_b) ped_b_q <= 1'b1;
            if (enter_walk) begin
                served_a_q <= ped_a_q;
                served_b_q <= ped_b_q;
            end
            if (state_q == ALLRED_A)      next_b_q <= 1'b1;
            else if (state_q == ALLRED_B) next_b_q <= 1'b0;
        end
    end

    // Moore decode of lamps, walk lamps and the countdown digit.
    always_comb begin
        va_o     = 1'b0;
        aa_o     = 1'b0;
        ra_o     = 1'b1;
        vb_o     = 1'b0;
        ab_o     = 1'b0;
        rb_o     = 1'b1;
        walk_a_o = 1'b0;
        walk_b_o = 1'b0;
        numero_o = tmr_q;
        case (state_q)
            GREEN_A: begin
                va_o     = 1'b1;
                ra_o     = 1'b0;
                numero_o = TMAXG - e_q;
            end
            YELLOW_A: begin
                aa_o = 1'b1;
                ra_o = 1'b0;
            end
            GREEN_B: begin
                vb_o     = 1'b1;
                rb_o     = 1'b0;
                numero_o = TMAXG - e_q;
            end
            YELLOW_B: begin
                ab_o = 1'b1;
                rb_o = 1'b0;
            end
            WALK: begin
                walk_a_o = served_a_q;
                walk_b_o = served_b_q;
            end
            default: ;
        endcase
    end

    assign phase_o = state_q;

endmodule
